pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32 core. Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Resolves four hazard classes:
  - load-use hazards;
  - taken-branch and privilege-return redirects;
  - CSR serialization;
  - instruction- and data-memory wait states.
- Also exposes stall and redirect performance counters.
- Pipeline registers consume `*_stall` (hold contents) and `*_flush` (load a bubble). When both are asserted for the same register, flush wins.

Parameters:
- CSR_DRAIN_CYCLES, 2, number of extra bubble cycles after a CSR op leaves EX, so it reaches WB before younger instructions proceed (range 1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_br_taken  in  1  EX branch/jump resolved taken
- ex_csr_op  in  2  EX CSR op code; nonzero means CSR access
- ex_priv_ret  in  2  EX privilege-return code; nonzero means xRET
- imem_ready  in  1  instruction fetch data valid this cycle
- mem_req  in  1  MEM stage issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_stall  out  1  hold PC
- pc_redirect  out  1  PC loads the EX-computed target
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  bubble IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  bubble ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_flush  out  1  bubble MEM/WB
- ctrl_state  out  2  registered state: 0 RUN, 1 CSR_DRAIN, 2 DMEM_WAIT
- perf_stall_cnt  out  CNT_W  cycles with pc_stall=1
- perf_redirect_cnt  out  CNT_W  cycles with pc_redirect=1

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
  - While rstn=0: ctrl_state=RUN, drain counter=0, both perf counters=0.
  - While rstn=0: if_id_flush=id_ex_flush=mem_wb_flush=1; all other control outputs=0.
  - Reset mid-drain or mid-wait aborts the drain/wait immediately.
- Control outputs are combinational from the inputs and the registered state, with zero latency. State and counters update on the rising clk edge.
- Defined terms:
  - dwait = mem_req & ~mem_ready.
  - redir = ex_br_taken | (ex_priv_ret != 0).
  - lu = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
  - csr_hit = (state == CSR_DRAIN) | (ex_csr_op != 0).
- Priority per cycle; the first match decides and all unlisted outputs are 0:
  1. dwait: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush. Any pending redirect, load-use or CSR in EX is held unchanged and is resolved in the first cycle after dwait clears.
  2. redir: pc_redirect, if_id_flush, id_ex_flush. PC is not stalled.
  3. csr_hit: pc_stall, if_id_stall, id_ex_flush.
  4. lu: pc_stall, if_id_stall, id_ex_flush. Lasts exactly one cycle; forwarding covers the rest.
  5. ~imem_ready: pc_stall, if_id_flush.
- FSM:
  - RUN -> CSR_DRAIN when ex_csr_op != 0 and no dwait. Drain counter is loaded with CSR_DRAIN_CYCLES.
  - CSR_DRAIN: the counter decrements each non-dwait cycle. When the counter == 1 and no dwait, return to RUN.
  - Any state -> DMEM_WAIT on a cycle with dwait. The pre-wait state is saved, and the counter is frozen while in DMEM_WAIT.
  - DMEM_WAIT -> saved state on the first cycle without dwait.
  - A CSR op appears in EX only once: during CSR_DRAIN, EX holds bubbles, so a redirect cannot occur.
- Total bubbles per CSR op, excluding dwait cycles: 1 + CSR_DRAIN_CYCLES.
- Perf counters:
  - Increment by 1 on each edge where the respective output is 1.
  - Wrap modulo 2^CNT_W with no saturation.

Test Plan:
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5); ID add with id_rs2=5, id_use_rs2=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0. perf_stall_cnt=1.
- x0 load: same stimulus with ex_rd=0 -> no stall.
- Branch: ex_br_taken=1 together with an active lu condition -> pc_redirect=if_id_flush=id_ex_flush=1, pc_stall=0. perf_redirect_cnt=1.
- CSR: ex_csr_op=1 for one cycle, then 0, with CSR_DRAIN_CYCLES=2 -> pc_stall=1 for exactly 3 cycles. ctrl_state sequence: 1,1,0.
- Dmem wait: mem_req=1, mem_ready=0 for 4 cycles with ex_br_taken=1 -> 4 cycles of full freeze and mem_wb_flush=1, ctrl_state=2, pc_redirect=0. Redirect fires in cycle 5.
- Dwait inside CSR drain: dwait asserted 3 cycles after the CSR trigger cycle -> drain still totals 2 non-wait cycles, then state returns to 0.
- Reset mid-drain: rstn=0 asynchronously -> ctrl_state=0 and counters=0 immediately; flush outputs=1.
- Wrap: CNT_W=4, 16 stall cycles -> perf_stall_cnt returns to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Handles load-use, redirect, CSR drain and memory wait states, and keeps two perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CSR_DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic [1:0]       ex_csr_op,
    input  logic [1:0]       ex_priv_ret,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_redirect_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CSR_DRAIN = 2'd1,
        DMEM_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] DRAIN_LOAD = 3'(CSR_DRAIN_CYCLES);

    state_e     state_q, state_d;
    state_e     saved_q, saved_d;
    logic [2:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, redir_cnt_q;

    logic   dwait, redir, lu, csr_hit;
    state_e eff_state;

    // While parked in DMEM_WAIT, decisions follow the state we will resume into.
    assign eff_state = (state_q == DMEM_WAIT) ? saved_q : state_q;

    assign dwait   = mem_req & ~mem_ready;
    assign redir   = ex_br_taken | (ex_priv_ret != 2'd0);
    assign lu      = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    assign csr_hit = (eff_state == CSR_DRAIN) | (ex_csr_op != 2'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        if (dwait) begin
            state_d = DMEM_WAIT;
            saved_d = eff_state;
        end else begin
            case (eff_state)
                RUN: begin
                    state_d = RUN;
                    if (ex_csr_op != 2'd0) begin
                        state_d = CSR_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
                CSR_DRAIN: begin
                    state_d = (cnt_q == 3'd1) ? RUN : CSR_DRAIN;
                    cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rstn) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (dwait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (redir) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (csr_hit || lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    // Free-running, wrapping counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (pc_stall)    stall_cnt_q <= stall_cnt_q + 1'b1;
            if (pc_redirect) redir_cnt_q <= redir_cnt_q + 1'b1;
        end
    end

    assign ctrl_state        = state_q;
    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a 4-bit-counter instance covers counter wrap.
module tb_pipe_hazard_ctrl;

    // ctl bit order: pc_stall pc_redirect if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall mem_wb_flush
    localparam logic [7:0] C_RST  = 8'b0001_0101;
    localparam logic [7:0] C_DW   = 8'b1010_1011;
    localparam logic [7:0] C_RD   = 8'b0101_0100;
    localparam logic [7:0] C_STL  = 8'b1010_0100;
    localparam logic [7:0] C_IM   = 8'b1001_0000;
    localparam logic [7:0] C_NONE = 8'b0000_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
    logic [1:0] ex_csr_op, ex_priv_ret;
    logic imem_ready, mem_req, mem_ready;

    logic pc_stall, pc_redirect, if_id_stall, if_id_flush;
    logic id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [1:0] ctrl_state;
    logic [31:0] perf_stall_cnt, perf_redirect_cnt;

    logic pc_stall4, pc_redirect4, if_id_stall4, if_id_flush4;
    logic id_ex_stall4, id_ex_flush4, ex_mem_stall4, mem_wb_flush4;
    logic [1:0] ctrl_state4;
    logic [3:0] perf_stall_cnt4, perf_redirect_cnt4;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CSR_DRAIN_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_csr_op(ex_csr_op),
        .ex_priv_ret(ex_priv_ret), .imem_ready(imem_ready), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_stall(pc_stall), .pc_redirect(pc_redirect),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
        .ctrl_state(ctrl_state), .perf_stall_cnt(perf_stall_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
    );

    pipe_hazard_ctrl #(.CSR_DRAIN_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken), .ex_csr_op(ex_csr_op),
        .ex_priv_ret(ex_priv_ret), .imem_ready(imem_ready), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_stall(pc_stall4), .pc_redirect(pc_redirect4),
        .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4), .id_ex_stall(id_ex_stall4),
        .id_ex_flush(id_ex_flush4), .ex_mem_stall(ex_mem_stall4), .mem_wb_flush(mem_wb_flush4),
        .ctrl_state(ctrl_state4), .perf_stall_cnt(perf_stall_cnt4),
        .perf_redirect_cnt(perf_redirect_cnt4)
    );

    wire [7:0] ctl = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
                      id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
        ex_csr_op = 2'd0; ex_priv_ret = 2'd0;
        imem_ready = 1'b1; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // Advance to the next cycle: inputs change after negedge, checks follow 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt(); #2;
        rstn = 1'b0;
        idle();
        nxt();
        rstn = 1'b1;
    endtask

    initial begin
        idle();
        #3;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_stallcnt", perf_stall_cnt, 32'd0);
        chk("rst_redircnt", perf_redirect_cnt, 32'd0);
        nxt(); rstn = 1'b1; #1;
        chk("idle_ctl", 32'(ctl), 32'(C_NONE));

        // Load-use on rs2
        nxt(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; #1;
        chk("lu_ctl", 32'(ctl), 32'(C_STL));
        nxt(); idle(); #1;
        chk("lu_after_ctl", 32'(ctl), 32'(C_NONE));
        chk("lu_stallcnt", perf_stall_cnt, 32'd1);

        // Matching register but not read: no hazard
        nxt(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; #1;
        chk("lu_unused_ctl", 32'(ctl), 32'(C_NONE));
        // Load to x0
        nxt(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1; #1;
        chk("lu_x0_ctl", 32'(ctl), 32'(C_NONE));

        // Taken branch overrides load-use
        nxt(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        ex_br_taken = 1'b1; #1;
        chk("br_ctl", 32'(ctl), 32'(C_RD));
        nxt(); idle(); #1;
        chk("br_redircnt", perf_redirect_cnt, 32'd1);
        chk("br_stallcnt", perf_stall_cnt, 32'd1);

        // xRET redirect
        nxt(); ex_priv_ret = 2'd2; #1;
        chk("xret_ctl", 32'(ctl), 32'(C_RD));
        // Fetch wait
        nxt(); idle(); imem_ready = 1'b0; #1;
        chk("imem_ctl", 32'(ctl), 32'(C_IM));
        nxt(); idle(); #1;
        chk("imem_stallcnt", perf_stall_cnt, 32'd2);
        chk("xret_redircnt", perf_redirect_cnt, 32'd2);

        // CSR drain: 3 stall cycles, state 1,1,0
        do_reset();
        ex_csr_op = 2'd1; #1;
        chk("csr0_ctl", 32'(ctl), 32'(C_STL));
        chk("csr0_state", 32'(ctrl_state), 32'd0);
        nxt(); ex_csr_op = 2'd0; #1;
        chk("csr1_ctl", 32'(ctl), 32'(C_STL));
        chk("csr1_state", 32'(ctrl_state), 32'd1);
        nxt(); #1;
        chk("csr2_ctl", 32'(ctl), 32'(C_STL));
        chk("csr2_state", 32'(ctrl_state), 32'd1);
        nxt(); #1;
        chk("csr3_ctl", 32'(ctl), 32'(C_NONE));
        chk("csr3_state", 32'(ctrl_state), 32'd0);
        chk("csr_stallcnt", perf_stall_cnt, 32'd3);

        // Dmem wait holds a pending branch for 4 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            mem_req = 1'b1; mem_ready = 1'b0; ex_br_taken = 1'b1; #1;
            chk("dw_ctl", 32'(ctl), 32'(C_DW));
            chk("dw_state", 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd2);
        end
        nxt(); mem_ready = 1'b1; #1;
        chk("dw_release_ctl", 32'(ctl), 32'(C_RD));
        chk("dw_release_state", 32'(ctrl_state), 32'd2);
        nxt(); idle(); #1;
        chk("dw_done_state", 32'(ctrl_state), 32'd0);
        chk("dw_stallcnt", perf_stall_cnt, 32'd4);
        chk("dw_redircnt", perf_redirect_cnt, 32'd1);

        // Dwait during CSR drain: drain still needs 2 non-wait cycles
        do_reset();
        ex_csr_op = 2'd1; #1;
        chk("cdw0_ctl", 32'(ctl), 32'(C_STL));
        for (int i = 0; i < 3; i++) begin
            nxt(); ex_csr_op = 2'd0; mem_req = 1'b1; mem_ready = 1'b0; #1;
            chk("cdw_wait_ctl", 32'(ctl), 32'(C_DW));
            chk("cdw_wait_state", 32'(ctrl_state), (i == 0) ? 32'd1 : 32'd2);
        end
        nxt(); idle(); #1;
        chk("cdw4_ctl", 32'(ctl), 32'(C_STL));
        nxt(); #1;
        chk("cdw5_ctl", 32'(ctl), 32'(C_STL));
        chk("cdw5_state", 32'(ctrl_state), 32'd1);
        nxt(); #1;
        chk("cdw6_ctl", 32'(ctl), 32'(C_NONE));
        chk("cdw6_state", 32'(ctrl_state), 32'd0);
        chk("cdw_stallcnt", perf_stall_cnt, 32'd6);

        // Asynchronous reset mid-drain
        do_reset();
        ex_csr_op = 2'd1;
        nxt(); ex_csr_op = 2'd0; #2;
        rstn = 1'b0; #1;
        chk("arst_state", 32'(ctrl_state), 32'd0);
        chk("arst_ctl", 32'(ctl), 32'(C_RST));
        chk("arst_stallcnt", perf_stall_cnt, 32'd0);
        nxt(); rstn = 1'b1; #1;
        chk("arst_after_ctl", 32'(ctl), 32'(C_NONE));
        chk("arst_after_state", 32'(ctrl_state), 32'd0);

        // 4-bit counter wraps after 16 stall cycles
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) nxt();
        #1;
        chk("wrap15_cnt4", 32'(perf_stall_cnt4), 32'd15);
        nxt(); #1;
        chk("wrap16_cnt4", 32'(perf_stall_cnt4), 32'd0);
        chk("wrap16_cnt32", perf_stall_cnt, 32'd16);
        idle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
